accum_arbiter: RTL and testbench

- Round-robin scheduler sharing one external saturating 16-bit accumulator among NREQ requesters.
- Each requester asks for a burst of req_len 8-bit samples; the block grants one requester and clears the accumulator.
- It then streams the granted requester's samples into the accumulator, waits for the sum to settle, and returns the tagged result over a valid/ready result port.
- It sits between the sample producers and the accumulator instance, and is the only driver of the accumulator's rst and in pins.

---
 rtl/accum_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_accum_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : accum_arbiter
// Brief    : Round-robin owner of a shared saturating 16-bit accumulator;
//            streams one requester's burst into it and returns the tagged sum.
// Revision : 1.0 - initial release
// ============================================================================
module accum_arbiter #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 10,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]       s_valid,
    input  logic [NREQ*8-1:0]     s_data,
    output logic [NREQ-1:0]       s_ready,
    output logic [NREQ-1:0]       grant,
    output logic                  acc_clr,
    output logic [7:0]            acc_in,
    input  logic [15:0]           acc_sum,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_sat,
    output logic                  busy
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLEAR  = 3'd1;
    localparam logic [2:0] c_STREAM = 3'd2;
    localparam logic [2:0] c_DRAIN  = 3'd3;
    localparam logic [2:0] c_RESULT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [15:0]      res_data_q, res_data_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic             res_sat_q, res_sat_d;

    logic             w_win_found;
    logic [ID_W-1:0]  w_win_idx;
    logic [ID_W:0]    w_cand;
    logic [NREQ-1:0]  w_win_onehot;
    logic [LEN_W-1:0] w_win_len;
    logic [7:0]       w_sel_data;
    logic             w_beat;

    // Search upward from rr_ptr with wrap; one extra bit keeps the sum from overflowing.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NREQ)) begin
                w_cand = w_cand - (ID_W+1)'(NREQ);
            end
            if (!w_win_found && req[w_cand[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_len    = '0;
        w_sel_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == ID_W'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_len       = req_len[i*LEN_W +: LEN_W];
            end
            if (grant_q[i]) begin
                w_sel_data = s_data[i*8 +: 8];
            end
        end
    end

    assign w_beat = (state_q == c_STREAM) && (|(s_valid & grant_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_sat_q   <= res_sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_sat_d   = res_sat_q;
        case (state_q)
            c_IDLE: begin
                if (w_win_found) begin
                    state_d = c_CLEAR;
                    grant_d = w_win_onehot;
                    cnt_d   = w_win_len;
                    id_d    = w_win_idx;
                end
            end
            c_CLEAR: begin
                state_d = (cnt_q != '0) ? c_STREAM : c_DRAIN;
            end
            c_STREAM: begin
                if (w_beat) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = c_DRAIN;
                    end
                end
            end
            // The final beat was added at the previous edge, so acc_sum is complete here.
            c_DRAIN: begin
                res_valid_d = 1'b1;
                res_data_d  = acc_sum;
                res_sat_d   = (acc_sum == 16'hFFFF);
                res_id_d    = id_q;
                state_d     = c_RESULT;
            end
            c_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    grant_d     = '0;
                    rr_ptr_d    = (id_q == ID_W'(NREQ-1)) ? '0 : id_q + ID_W'(1);
                    state_d     = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // The accumulator has no enable, so acc_in must be zero on every non-beat cycle.
    always_comb begin
        s_ready = '0;
        acc_in  = 8'h00;
        if (state_q == c_STREAM) begin
            s_ready = grant_q;
            if (w_beat) begin
                acc_in = w_sel_data;
            end
        end
        acc_clr = rst | (state_q == c_CLEAR);
        busy    = (state_q != c_IDLE);
    end

    assign grant     = grant_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_sat   = res_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_arbiter
// Brief    : Self-checking bench for accum_arbiter with a behavioural
//            saturating accumulator and a round-robin service-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_arbiter;

    localparam int NREQ  = 4;
    localparam int LEN_W = 10;
    localparam int ID_W  = 2;

    typedef struct {
        int id;
        int len;
        int gap;
        int bp;
        int base;
        int step;
        int exp_sum;
        int exp_sat;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       s_valid;
    logic [NREQ*8-1:0]     s_data;
    logic [NREQ-1:0]       s_ready;
    logic [NREQ-1:0]       grant;
    logic                  acc_clr;
    logic [7:0]            acc_in;
    logic [15:0]           acc_sum;
    logic                  res_valid;
    logic                  res_ready;
    logic [15:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_sat;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    accum_arbiter #(
        .NREQ  (NREQ),
        .LEN_W (LEN_W),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .grant     (grant),
        .acc_clr   (acc_clr),
        .acc_in    (acc_in),
        .acc_sum   (acc_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_sat   (res_sat),
        .busy      (busy)
    );

    // External accumulator: synchronous clear, saturating add every cycle.
    always @(posedge clk) begin
        if (acc_clr) acc_sum <= 16'h0000;
        else if (({1'b0, acc_sum} + {9'h000, acc_in}) > 17'h0FFFF) acc_sum <= 16'hFFFF;
        else acc_sum <= acc_sum + {8'h00, acc_in};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic reset_dut();
        req       = '0;
        s_valid   = '0;
        res_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_burst(input vec_t v);
        int beat_i, gapcnt, lat, clr_cnt, rdy_cnt, accin_err, proto_err, bp_err;
        int exp_lat, exp_rdy, other;
        logic [7:0] d;
        logic beat;
        beat_i = 0; gapcnt = 0; lat = 0; clr_cnt = 0; rdy_cnt = 0;
        accin_err = 0; proto_err = 0; bp_err = 0;
        other = (v.id + 1) % NREQ;
        req_len[v.id*LEN_W +: LEN_W] = LEN_W'(v.len);
        req[v.id] = 1'b1;
        for (int cyc = 0; cyc < 2500 && !res_valid; cyc++) begin
            d = 8'((v.base + beat_i * v.step) & 255);
            s_valid[v.id] = (beat_i < v.len) && (gapcnt == 0);
            s_data[v.id*8 +: 8] = d;
            #1;
            beat = s_valid[v.id] & s_ready[v.id];
            if (acc_in !== (beat ? d : 8'h00)) accin_err++;
            if (acc_clr) clr_cnt++;
            if (s_ready[v.id]) rdy_cnt++;
            if ($countones(grant) > 1 || (s_ready & ~grant) != '0) proto_err++;
            if (beat) begin
                beat_i++;
                gapcnt = v.gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
            @(negedge clk);
            lat++;
            // Grant is committed: dropping req and scrambling the length must not matter.
            if (grant[v.id]) begin
                req[v.id] = 1'b0;
                req_len[v.id*LEN_W +: LEN_W] = ~LEN_W'(v.len);
            end
        end
        s_valid[v.id] = 1'b0;
        exp_rdy = (v.len > 0) ? v.len + v.gap * (v.len - 1) : 0;
        exp_lat = exp_rdy + 3;
        chk("burst_res_valid", res_valid, 1);
        chk("burst_res_data", res_data, v.exp_sum);
        chk("burst_res_id", res_id, v.id);
        chk("burst_res_sat", res_sat, v.exp_sat);
        chk("burst_latency", lat, exp_lat);
        chk("burst_acc_clr_cycles", clr_cnt, 1);
        chk("burst_s_ready_cycles", rdy_cnt, exp_rdy);
        chk("burst_acc_in_errs", accin_err, 0);
        chk("burst_protocol_errs", proto_err, 0);
        if (v.bp > 0) begin
            req[other] = 1'b1;
            for (int k = 0; k < v.bp; k++) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_data !== 16'(v.exp_sum) || res_id !== ID_W'(v.id) ||
                    res_sat !== 1'(v.exp_sat) || grant !== (NREQ'(1) << v.id) ||
                    s_ready !== '0 || acc_in !== 8'h00) bp_err++;
            end
            chk("backpressure_stable_errs", bp_err, 0);
        end
        res_ready  = 1'b1;
        req[other] = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        chk("accept_to_idle", {29'd0, res_valid, busy, |grant}, 0);
    endtask

    task automatic run_rr();
        int nres, proto;
        reset_dut();
        for (int i = 0; i < NREQ; i++) begin
            s_data[i*8 +: 8] = 8'(i + 1);
            req_len[i*LEN_W +: LEN_W] = LEN_W'(1);
        end
        s_valid   = '1;
        res_ready = 1'b1;
        req       = '1;
        nres = 0; proto = 0;
        for (int c = 0; c < 100 && nres < 5; c++) begin
            @(negedge clk);
            if ($countones(grant) > 1) proto++;
            if (res_valid) begin
                chk("rr_id", res_id, nres % NREQ);
                chk("rr_data", res_data, (nres % NREQ) + 1);
                nres++;
                if (nres == 5) req = '0;
            end
        end
        chk("rr_result_count", nres, 5);
        chk("rr_onehot_errs", proto, 0);
        @(negedge clk);
        res_ready = 1'b0;
        s_valid   = '0;
        @(negedge clk);
        chk("rr_idle_after", busy, 0);
    endtask

    task automatic run_mid_reset();
        int beats;
        vec_t rv;
        reset_dut();
        req_len[0 +: LEN_W] = LEN_W'(5);
        s_data[7:0] = 8'd9;
        s_valid[0]  = 1'b1;
        req[0]      = 1'b1;
        beats = 0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            #1;
            if (s_valid[0] && s_ready[0]) beats++;
            @(negedge clk);
        end
        chk("mid_beats_taken", beats, 2);
        rst = 1'b1;
        #1;
        chk("mid_acc_clr_in_rst", acc_clr, 1);
        @(negedge clk);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        rst = 1'b0;
        req = '0;
        s_valid = '0;
        @(negedge clk);
        chk("mid_post_acc_clr", acc_clr, 0);
        rv = '{1, 2, 0, 0, 3, 1, 7, 0};
        do_burst(rv);
    endtask

    // Reference: service order is the first pending requester at or after ptr.
    task automatic run_random();
        int ptr, exp_id, exp_sum, waited;
        int lens[NREQ];
        int vals[NREQ];
        logic [NREQ-1:0] pending;
        reset_dut();
        ptr = 0;
        for (int r = 0; r < 10; r++) begin
            pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                lens[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 280))
                                                      : int'($urandom_range(0, 20));
                vals[i] = int'($urandom_range(0, 255));
                req_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
                s_data[i*8 +: 8] = 8'(vals[i]);
            end
            req = pending;
            while (pending != '0) begin
                exp_id = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (exp_id < 0 && pending[(ptr + k) % NREQ]) exp_id = (ptr + k) % NREQ;
                end
                exp_sum = lens[exp_id] * vals[exp_id];
                if (exp_sum > 65535) exp_sum = 65535;
                waited = 0;
                while (!res_valid && waited < 1500) begin
                    s_valid = NREQ'($urandom);
                    @(negedge clk);
                    waited++;
                end
                chk("rnd_res_valid", res_valid, 1);
                if (!res_valid) begin
                    reset_dut();
                    ptr = 0;
                    pending = '0;
                end else begin
                    chk("rnd_res_id", res_id, exp_id);
                    chk("rnd_res_data", res_data, exp_sum);
                    chk("rnd_res_sat", res_sat, (exp_sum == 65535) ? 1 : 0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    res_ready = 1'b1;
                    @(negedge clk);
                    res_ready = 1'b0;
                    req[exp_id] = 1'b0;
                    pending[exp_id] = 1'b0;
                    ptr = (exp_id + 1) % NREQ;
                end
            end
        end
        s_valid = '0;
    endtask

    initial begin
        // {id, len, gap, backpressure, first data, data step, sum, sat}
        vecs[0] = '{0,    4, 0, 0,  10, 10,   100, 0};
        vecs[1] = '{1,    3, 2, 0,   5,  1,    18, 0};
        vecs[2] = '{2,  300, 0, 0, 255,  0, 65535, 1};
        vecs[3] = '{3,    0, 0, 0,   0,  0,     0, 0};
        vecs[4] = '{2,    5, 0, 5,   1,  1,    15, 0};
        vecs[5] = '{3,  257, 0, 0, 255,  0, 65535, 1};
        vecs[6] = '{0,  256, 0, 0,   0,  1, 32640, 0};
        vecs[7] = '{1, 1023, 0, 1,   0,  0,     0, 0};
        vecs[8] = '{2,    7, 1, 2, 250,  1,  1515, 0};

        rst = 1'b1; req = '0; req_len = '0; s_valid = '0; s_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_grant", grant, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_res_sat", res_sat, 0);
        chk("reset_busy", busy, 0);
        chk("reset_acc_clr", acc_clr, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_acc_clr", acc_clr, 0);

        for (int t = 0; t < 9; t++) do_burst(vecs[t]);
        run_rr();
        run_mid_reset();
        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
